// File: rtl/sd_spi_card_responder_if.sv
// SD SPI-mode card link: host serial pins plus the card's block-RAM read port and status.
// "master" is the host/RAM side and "slave" is the card responder.
interface sd_spi_card_responder_if;
  logic        cs;
  logic        spi_clk;
  logic        mosi;
  logic        miso;
  logic        mem_req;
  logic [31:0] mem_block;
  logic [8:0]  mem_offset;
  logic [7:0]  mem_data;
  logic        card_ready;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;

  modport master (
    output cs, spi_clk, mosi, mem_data,
    input  miso, mem_req, mem_block, mem_offset, card_ready, cmd_strobe, cmd_index
  );

  modport slave (
    input  cs, spi_clk, mosi, mem_data,
    output miso, mem_req, mem_block, mem_offset, card_ready, cmd_strobe, cmd_index
  );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SD SPI-mode card responder: decodes 6-byte commands and answers with R1/R3/R7 and CMD17 block reads.
// The next byte is chosen at the 8th rise of the current byte; RAM bytes are prefetched one byte ahead.
module sd_spi_card_responder #(
  parameter int ACMD41_POLLS = 2,
  parameter int NCR_BYTES    = 1,
  parameter int NAC_BYTES    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sd_spi_card_responder_if.slave     bus
);

  typedef enum logic [2:0] {LISTEN, RX_CMD, NCR, RESP, NAC, TOKEN, DATA, CRC} state_t;

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [1:0]  sclk_sync, mosi_sync;
  logic        sclk_d;
  logic        rise, fall;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, rx_byte, tx_reg;
  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  frame_cnt;
  logic [5:0]  idx_reg;
  logic [31:0] arg_reg;
  logic [39:0] resp_buf;
  logic [2:0]  resp_left;
  logic        data_phase;
  logic        idle, app_cmd;
  logic [7:0]  poll_cnt;
  logic [8:0]  dcnt;
  logic [15:0] crc16;
  logic [7:0]  data_buf;
  logic        req_d;

  logic        crc_bad, n_idle, n_ready, n_app, n_data;
  logic [7:0]  n_poll, r1;
  logic [39:0] n_resp;
  logic [2:0]  n_len;

  assign rise    = sclk_sync[1] & ~sclk_d;
  assign fall    = ~sclk_sync[1] & sclk_d;
  assign rx_byte = {rx_shift[6:0], mosi_sync[1]};

  // Decode of the frame being completed; rx_byte holds the CRC byte at that moment.
  always_comb begin
    r1      = {7'b0, idle};
    crc_bad = ((idx_reg == 6'd0) || (idx_reg == 6'd8)) &&
              (crc7_40({2'b01, idx_reg, arg_reg}) != rx_byte[7:1]);
    n_idle  = idle;
    n_ready = bus.card_ready;
    n_poll  = poll_cnt;
    n_app   = 1'b0;
    n_data  = 1'b0;
    n_len   = 3'd1;
    n_resp  = {r1 | 8'h04, 32'h0};
    if (crc_bad) begin
      n_app  = app_cmd;
      n_resp = {(idle ? 8'h09 : 8'h08), 32'h0};
    end else begin
      case (idx_reg)
        6'd0: begin
          n_idle  = 1'b1;
          n_ready = 1'b0;
          n_poll  = 8'd0;
          n_resp  = {8'h01, 32'h0};
        end
        6'd8: if (arg_reg[11:8] == 4'd1) begin
          n_resp = {r1, 16'h0000, 8'h01, arg_reg[7:0]};
          n_len  = 3'd5;
        end
        6'd55: begin
          n_resp = {r1, 32'h0};
          n_app  = 1'b1;
        end
        6'd41: if (app_cmd) begin
          if (poll_cnt < 8'(ACMD41_POLLS)) begin
            n_resp = {8'h01, 32'h0};
            n_poll = poll_cnt + 8'd1;
          end else begin
            n_idle  = 1'b0;
            n_ready = 1'b1;
            n_resp  = {8'h00, 32'h0};
          end
        end
        6'd58: begin
          n_resp = {r1, (idle ? 32'h40FF8000 : 32'hC0FF8000)};
          n_len  = 3'd5;
        end
        6'd17: begin
          n_resp = {(idle ? 8'h05 : 8'h00), 32'h0};
          n_data = ~idle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync      <= '0;
      mosi_sync      <= '1;
      sclk_d         <= 1'b0;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_reg         <= 8'hFF;
      state          <= LISTEN;
      cnt            <= '0;
      frame_cnt      <= '0;
      idx_reg        <= '0;
      arg_reg        <= '0;
      resp_buf       <= '0;
      resp_left      <= '0;
      data_phase     <= 1'b0;
      idle           <= 1'b1;
      app_cmd        <= 1'b0;
      poll_cnt       <= '0;
      dcnt           <= '0;
      crc16          <= '0;
      data_buf       <= '0;
      req_d          <= 1'b0;
      bus.miso       <= 1'b1;
      bus.mem_req    <= 1'b0;
      bus.mem_block  <= '0;
      bus.mem_offset <= '0;
      bus.card_ready <= 1'b0;
      bus.cmd_strobe <= 1'b0;
      bus.cmd_index  <= '0;
    end else begin
      sclk_sync      <= {sclk_sync[0], bus.spi_clk};
      mosi_sync      <= {mosi_sync[0], bus.mosi};
      sclk_d         <= sclk_sync[1];
      bus.mem_req    <= 1'b0;
      bus.cmd_strobe <= 1'b0;
      req_d          <= bus.mem_req;
      if (req_d)
        data_buf <= bus.mem_data;

      if (bus.cs) begin
        bit_cnt  <= '0;
        state    <= LISTEN;
        tx_reg   <= 8'hFF;
        bus.miso <= 1'b1;
      end else if (fall) begin
        bus.miso <= tx_reg[7];
        tx_reg   <= {tx_reg[6:0], 1'b1};
      end else if (rise) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          tx_reg <= 8'hFF;
          case (state)
            LISTEN: if (rx_byte[7:6] == 2'b01) begin
              idx_reg   <= rx_byte[5:0];
              frame_cnt <= 3'd1;
              state     <= RX_CMD;
            end
            RX_CMD: if (frame_cnt != 3'd5) begin
              arg_reg   <= {arg_reg[23:0], rx_byte};
              frame_cnt <= frame_cnt + 3'd1;
            end else begin
              bus.cmd_strobe <= 1'b1;
              bus.cmd_index  <= idx_reg;
              bus.card_ready <= n_ready;
              idle           <= n_idle;
              poll_cnt       <= n_poll;
              app_cmd        <= n_app;
              resp_buf       <= n_resp;
              resp_left      <= n_len;
              data_phase     <= n_data;
              if (n_data)
                bus.mem_block <= arg_reg;
              cnt   <= 8'(NCR_BYTES - 1);
              state <= NCR;
            end
            NCR: if (cnt == 8'd0) begin
              tx_reg    <= resp_buf[39:32];
              resp_buf  <= {resp_buf[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
              state     <= RESP;
            end else begin
              cnt <= cnt - 8'd1;
            end
            RESP: if (resp_left != 3'd0) begin
              tx_reg    <= resp_buf[39:32];
              resp_buf  <= {resp_buf[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
            end else if (data_phase) begin
              cnt   <= 8'(NAC_BYTES - 1);
              state <= NAC;
            end else begin
              state <= LISTEN;
            end
            // The first RAM fetch leaves with the token so byte 0 is ready one byte later.
            NAC: if (cnt == 8'd0) begin
              tx_reg         <= 8'hFE;
              crc16          <= 16'h0000;
              bus.mem_req    <= 1'b1;
              bus.mem_offset <= 9'd0;
              state          <= TOKEN;
            end else begin
              cnt <= cnt - 8'd1;
            end
            TOKEN: begin
              tx_reg         <= data_buf;
              crc16          <= crc16_byte(crc16, data_buf);
              bus.mem_req    <= 1'b1;
              bus.mem_offset <= bus.mem_offset + 9'd1;
              dcnt           <= 9'd0;
              state          <= DATA;
            end
            DATA: if (dcnt == 9'd511) begin
              tx_reg <= crc16[15:8];
              cnt    <= 8'd0;
              state  <= CRC;
            end else begin
              tx_reg <= data_buf;
              crc16  <= crc16_byte(crc16, data_buf);
              dcnt   <= dcnt + 9'd1;
              if (dcnt != 9'd510) begin
                bus.mem_req    <= 1'b1;
                bus.mem_offset <= bus.mem_offset + 9'd1;
              end
            end
            CRC: if (cnt == 8'd0) begin
              tx_reg <= crc16[7:0];
              cnt    <= 8'd1;
            end else begin
              state <= LISTEN;
            end
            default: state <= LISTEN;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench: a mode-0 SPI host and a byte RAM returning offset[7:0] drive the card responder.
// Expected bytes are hand-derived constants; the block CRC16 comes from a small bitwise model.
module tb_sd_spi_card_responder;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   strobe_cnt = 0;
  int   req_cnt = 0;

  sd_spi_card_responder_if bus();

  sd_spi_card_responder #(.ACMD41_POLLS(2), .NCR_BYTES(1), .NAC_BYTES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_req)    bus.mem_data <= bus.mem_offset[7:0];
    if (bus.mem_req)    req_cnt      <= req_cnt + 1;
    if (bus.cmd_strobe) strobe_cnt   <= strobe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_clk = 1'b0;
      bus.mosi    = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i]       = bus.miso;
      bus.spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [47:0] f;
    logic [7:0]  b;
    f = {2'b01, idx, arg, crc};
    xfer(8'hFF, b);
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], b);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                          input int nresp, output logic [7:0] ncr, output logic [39:0] resp);
    logic [7:0] b;
    send_frame(idx, arg, crc);
    xfer(8'hFF, ncr);
    resp = '0;
    for (int i = 0; i < nresp; i++) begin
      xfer(8'hFF, b);
      resp = {resp[31:0], b};
    end
  endtask

  function automatic logic [15:0] model_crc16();
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'h0000;
    for (int k = 0; k < 512; k++) begin
      d = k[7:0];
      for (int i = 7; i >= 0; i--)
        c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  logic [7:0]  ncr, b;
  logic [39:0] resp;
  logic [15:0] crc_rx;
  int          s0, r0;

  initial begin
    rst_n       = 1'b0;
    bus.cs      = 1'b1;
    bus.spi_clk = 1'b0;
    bus.mosi    = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_miso",   bus.miso, 1);
    check_eq("rst_req",    bus.mem_req, 0);
    check_eq("rst_ready",  bus.card_ready, 0);
    check_eq("rst_strobe", bus.cmd_strobe, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("idle_miso", bus.miso, 1);
    bus.cs = 1'b0;

    // CMD0
    s0 = strobe_cnt;
    send_cmd(6'd0, 32'h0, 8'h95, 1, ncr, resp);
    check_eq("cmd0_ncr", ncr, 8'hFF);
    check_eq("cmd0_r1", resp, 40'h01);
    check_eq("cmd0_strobes", strobe_cnt - s0, 1);
    check_eq("cmd0_index", bus.cmd_index, 6'd0);

    // CMD8 good and bad CRC
    send_cmd(6'd8, 32'h000001AA, 8'h87, 5, ncr, resp);
    check_eq("cmd8_ncr", ncr, 8'hFF);
    check_eq("cmd8_r7", resp, 40'h01000001AA);
    check_eq("cmd8_index", bus.cmd_index, 6'd8);
    send_cmd(6'd8, 32'h000001AA, 8'h00, 1, ncr, resp);
    check_eq("cmd8_badcrc", resp, 40'h09);

    // Initialisation loop
    send_cmd(6'd55, 32'h0, 8'h01, 1, ncr, resp);
    check_eq("cmd55_a", resp, 40'h01);
    send_cmd(6'd41, 32'h40000000, 8'h01, 1, ncr, resp);
    check_eq("acmd41_a", resp, 40'h01);
    send_cmd(6'd55, 32'h0, 8'h01, 1, ncr, resp);
    send_cmd(6'd41, 32'h40000000, 8'h01, 1, ncr, resp);
    check_eq("acmd41_b", resp, 40'h01);
    check_eq("ready_b", bus.card_ready, 0);
    send_cmd(6'd55, 32'h0, 8'h01, 1, ncr, resp);
    send_cmd(6'd41, 32'h40000000, 8'h01, 1, ncr, resp);
    check_eq("acmd41_c", resp, 40'h00);
    check_eq("ready_c", bus.card_ready, 1);
    send_cmd(6'd58, 32'h0, 8'h01, 5, ncr, resp);
    check_eq("cmd58_ready", resp, 40'h00C0FF8000);

    // Full block read
    r0 = req_cnt;
    send_cmd(6'd17, 32'h00000007, 8'h01, 1, ncr, resp);
    check_eq("cmd17_r1", resp, 40'h00);
    check_eq("cmd17_block", bus.mem_block, 32'h7);
    xfer(8'hFF, b); check_eq("nac0", b, 8'hFF);
    xfer(8'hFF, b); check_eq("nac1", b, 8'hFF);
    xfer(8'hFF, b); check_eq("token", b, 8'hFE);
    for (int k = 0; k < 512; k++) begin
      xfer(8'hFF, b);
      check_eq($sformatf("data%0d", k), b, k % 256);
    end
    xfer(8'hFF, b); crc_rx[15:8] = b;
    xfer(8'hFF, b); crc_rx[7:0]  = b;
    check_eq("crc16", crc_rx, model_crc16());
    check_eq("req_count", req_cnt - r0, 512);
    check_eq("offset_end", bus.mem_offset, 9'd511);

    // Reads and unknown commands while idle
    send_cmd(6'd0, 32'h0, 8'h95, 1, ncr, resp);
    check_eq("cmd0_again", resp, 40'h01);
    check_eq("ready_cleared", bus.card_ready, 0);
    r0 = req_cnt;
    send_cmd(6'd17, 32'h00000007, 8'h01, 1, ncr, resp);
    check_eq("cmd17_idle", resp, 40'h05);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    check_eq("cmd17_idle_tail", b, 8'hFF);
    check_eq("cmd17_idle_noreq", req_cnt - r0, 0);
    send_cmd(6'd5, 32'h0, 8'h01, 1, ncr, resp);
    check_eq("cmd5_idle", resp, 40'h05);

    // Abort a read with cs, then resume
    for (int n = 0; n < 3; n++) begin
      send_cmd(6'd55, 32'h0, 8'h01, 1, ncr, resp);
      send_cmd(6'd41, 32'h40000000, 8'h01, 1, ncr, resp);
    end
    check_eq("reinit_r1", resp, 40'h00);
    send_cmd(6'd17, 32'h00000003, 8'h01, 1, ncr, resp);
    check_eq("cmd17b_r1", resp, 40'h00);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    check_eq("cmd17b_token", b, 8'hFE);
    for (int k = 0; k <= 100; k++) begin
      xfer(8'hFF, b);
      if (k == 100) check_eq("data100_before_abort", b, 8'd100);
    end
    bus.cs = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort_miso", bus.miso, 1);
    r0 = req_cnt;
    for (int i = 0; i < 16; i++) begin
      bus.spi_clk = ~bus.spi_clk;
      repeat (HALF) @(negedge clk);
    end
    bus.spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    check_eq("abort_noreq", req_cnt - r0, 0);
    check_eq("abort_miso_hold", bus.miso, 1);
    bus.cs = 1'b0;
    send_cmd(6'd58, 32'h0, 8'h01, 5, ncr, resp);
    check_eq("cmd58_after_abort", resp, 40'h00C0FF8000);

    // Reset in the middle of an R7
    send_frame(6'd8, 32'h000001AA, 8'h87);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    check_eq("r7_partial", b, 8'h00);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_miso",   bus.miso, 1);
    check_eq("mid_rst_req",    bus.mem_req, 0);
    check_eq("mid_rst_block",  bus.mem_block, 32'h0);
    check_eq("mid_rst_offset", bus.mem_offset, 9'd0);
    check_eq("mid_rst_ready",  bus.card_ready, 0);
    check_eq("mid_rst_strobe", bus.cmd_strobe, 0);
    check_eq("mid_rst_index",  bus.cmd_index, 6'd0);
    bus.cs      = 1'b1;
    bus.spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
